lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//   Parametrised leaky integrate-and-fire neuron. Integrates weighted spikes from N_IN channels on each enabled step.
//   Applies shift-based leak and fires a one-cycle spike when the membrane potential reaches threshold.
//   Then holds a refractory period. Generalises the fixed 4x4-bit neuron stage of the spiking datapath.
// PARAMETERS
//   N_IN        4   number of input channels
//   IN_W        4   per-channel weight width (unsigned magnitude)
//   POT_W       8   membrane potential width (unsigned, saturating)
//   LEAK_SHIFT  2   leak = pot >> LEAK_SHIFT per step; 0 = full reset each step
//   REFRAC      3   refractory steps after a spike; 0 = none
//   CNT_W       8   spike counter width
// PORTS
//   clk         in   1            clock
//   rst_n       in   1            reset, synchronous, active-low
//   en          in   1            step strobe; state updates only when high
//   in_spike    in   N_IN         per-channel spike this step
//   inhib       in   N_IN         1 = channel is inhibitory (weight subtracted)
//   weight      in   N_IN*IN_W    packed weights, channel i at [i*IN_W +: IN_W]
//   threshold   in   POT_W        fire level; 0 disables firing
//   spike_out   out  1            registered one-cycle fire pulse
//   potential   out  POT_W        current membrane potential
//   refractory  out  1            high while refractory counter != 0
//   spike_count out  CNT_W        total spikes since reset, wraps mod 2^CNT_W
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): potential=0, refr_cnt=0, spike_out=0, spike_count=0. Overrides en.
//   - en=0: potential, refr_cnt, spike_count hold; spike_out=0.
//   - en=1 and refr_cnt!=0: refr_cnt-=1, potential forced 0, inputs ignored, spike_out=0.
//   - en=1 and refr_cnt==0:
//       exc = sum weight[i] over in_spike[i]&~inhib[i]; inh = same over in_spike[i]&inhib[i]
//       leaked = pot - (pot >> LEAK_SHIFT)
//       nxt = leaked + exc - inh, evaluated signed at POT_W+IN_W+$clog2(N_IN)+1 bits
//       clamp nxt to [0, 2^POT_W-1]
//       if threshold!=0 && nxt>=threshold: spike_out=1, potential=0, refr_cnt=REFRAC, spike_count+=1
//       else potential=nxt, spike_out=0
//   - Latency: spike_out and potential reflect step k on the cycle after the en edge of step k.
//   - Back-to-back fires possible only when REFRAC=0.
//   - refractory = (refr_cnt != 0), registered state, no combinational path from inputs.
//   - Mid-refractory reset clears counter immediately; next enabled step integrates normally.
//   - All outputs registered or direct decodes of registers; no input-to-output comb path.
// STRUCTURE
//   - Package lif_pkg: default parameter constants, function for sum width, clamp helper.
//   - Sub-module lif_weight_sum: combinational exc/inh adder over N_IN channels.
//   - Top holds potential, refr_cnt, spike_count, spike_out registers.
// TESTING (defaults unless stated; threshold=20)
//   1 in_spike=0001 inhib=0 weight0=5, en every cycle -> potential 5,9,12,14,16,17,18,19;
//     9th step spike_out=1 one cycle, potential=0, spike_count=1.
//   2 continue stimulus of 1 -> refractory=1 for 3 steps with potential=0;
//     4th step potential=5.
//   3 pot=9, in_spike=1111 inhib=1111 all weights 15 -> potential clamps to 0, no spike.
//   4 LEAK_SHIFT=4, threshold=0, all channels exc weight 15 -> potential rises and saturates at 255;
//     no spike, count stays 0.
//   5 en toggled 1,0,0,1 with 1's stimulus -> potential 5,5,5,9; spike_out never high while en=0.
//   6 rst_n=0 during refractory step 1 -> next cycle all outputs 0;
//     first en step after release gives potential=5.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default parameter values, weight-sum width function, saturating clamp, step decode enum.
package lif_pkg;

  localparam int DEF_N_IN       = 4;
  localparam int DEF_IN_W       = 4;
  localparam int DEF_POT_W      = 8;
  localparam int DEF_LEAK_SHIFT = 2;
  localparam int DEF_REFRAC     = 3;
  localparam int DEF_CNT_W      = 8;

  // What a clock edge does to the neuron state.
  typedef enum logic [1:0] {
    STEP_HOLD   = 2'd0,  // en low: state frozen
    STEP_REFRAC = 2'd1,  // counting down refractory period
    STEP_INTEG  = 2'd2   // integrating inputs
  } step_e;

  // Bits needed for a sum of n_in unsigned in_w-bit weights.
  // n_in * (2^in_w - 1) < 2^(in_w + clog2(n_in)) for all n_in >= 1.
  function automatic int sum_width(input int n_in, input int in_w);
    return in_w + $clog2(n_in);
  endfunction

  // Saturate a signed value into the unsigned range [0, 2^w - 1].
  function automatic longint clamp_unsigned(input longint v, input int w);
    longint hi;
    hi = (longint'(1) << w) - 1;
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Step-input / state-output bundle between a spike source and one neuron.
// Latency: n/a (wires only). Backpressure: none; the neuron accepts every en step.
// master drives en/in_spike/inhib/weight/threshold; slave (the neuron) drives
// spike_out/potential/refractory/spike_count.
interface lif_neuron_if
  import lif_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int IN_W  = DEF_IN_W,
  parameter int POT_W = DEF_POT_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic                   en;
  logic [N_IN-1:0]        in_spike;
  logic [N_IN-1:0]        inhib;
  logic [N_IN*IN_W-1:0]   weight;
  logic [POT_W-1:0]       threshold;
  logic                   spike_out;
  logic [POT_W-1:0]       potential;
  logic                   refractory;
  logic [CNT_W-1:0]       spike_count;

  modport master (
    output en, in_spike, inhib, weight, threshold,
    input  spike_out, potential, refractory, spike_count
  );

  modport slave (
    input  en, in_spike, inhib, weight, threshold,
    output spike_out, potential, refractory, spike_count
  );

endinterface

// File: rtl/lif_weight_sum.sv
// Splits active input channels into excitatory and inhibitory weight sums.
// Latency: purely combinational. Backpressure: none.
// Ports: in_spike/inhib (N_IN), weight (packed N_IN*IN_W) in; exc/inh (SUM_W) out.
module lif_weight_sum
  import lif_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int IN_W  = DEF_IN_W,
  parameter int SUM_W = sum_width(N_IN, IN_W)
) (
  input  logic [N_IN-1:0]      in_spike,
  input  logic [N_IN-1:0]      inhib,
  input  logic [N_IN*IN_W-1:0] weight,
  output logic [SUM_W-1:0]     exc,
  output logic [SUM_W-1:0]     inh
);

  always_comb begin
    exc = '0;
    inh = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_spike[i] && !inhib[i]) exc = exc + SUM_W'(weight[i*IN_W +: IN_W]);
      if (in_spike[i] &&  inhib[i]) inh = inh + SUM_W'(weight[i*IN_W +: IN_W]);
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: leak, integrate weighted spikes, fire at threshold, refractory hold.
// Latency: outputs reflect an en step on the cycle after that step's clock edge.
// Backpressure: none; en=0 freezes state and every en=1 cycle is one step.
// Ports: clk, rst_n (sync, active-low), nrn (lif_neuron_if.slave).
module lif_neuron
  import lif_pkg::*;
#(
  parameter int N_IN       = DEF_N_IN,
  parameter int IN_W       = DEF_IN_W,
  parameter int POT_W      = DEF_POT_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  lif_neuron_if.slave nrn
);

  localparam int SUM_W    = sum_width(N_IN, IN_W);
  // One extra bit over pot+sum so leaked+exc-inh never overflows as signed.
  localparam int NXT_W    = POT_W + SUM_W + 1;
  localparam int REFRAC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [POT_W-1:0]    potential_q;
  logic [REFRAC_W-1:0] refr_cnt_q;
  logic [CNT_W-1:0]    spike_count_q;
  logic                spike_out_q;

  logic [SUM_W-1:0]        exc;
  logic [SUM_W-1:0]        inh;
  logic [POT_W-1:0]        leaked;
  logic signed [NXT_W-1:0] nxt;
  logic [POT_W-1:0]        pot_clamped;
  logic                    fire;
  step_e                   step;

  lif_weight_sum #(
    .N_IN  (N_IN),
    .IN_W  (IN_W),
    .SUM_W (SUM_W)
  ) u_weight_sum (
    .in_spike (nrn.in_spike),
    .inhib    (nrn.inhib),
    .weight   (nrn.weight),
    .exc      (exc),
    .inh      (inh)
  );

  // LEAK_SHIFT=0 leaks the whole potential away each step.
  assign leaked = potential_q - (potential_q >> LEAK_SHIFT);

  assign nxt = $signed({{(SUM_W + 1){1'b0}}, leaked})
             + $signed({{(POT_W + 1){1'b0}}, exc})
             - $signed({{(POT_W + 1){1'b0}}, inh});

  assign pot_clamped = POT_W'(clamp_unsigned(longint'(nxt), POT_W));

  // Threshold 0 disables firing so the potential can saturate instead.
  assign fire = (nrn.threshold != '0) && (pot_clamped >= nrn.threshold);

  always_comb begin
    step = STEP_HOLD;
    if (nrn.en) begin
      if (refr_cnt_q != '0) step = STEP_REFRAC;
      else                  step = STEP_INTEG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      potential_q   <= '0;
      refr_cnt_q    <= '0;
      spike_count_q <= '0;
      spike_out_q   <= 1'b0;
    end else begin
      spike_out_q <= 1'b0;
      unique case (step)
        STEP_REFRAC: begin
          refr_cnt_q  <= refr_cnt_q - REFRAC_W'(1);
          potential_q <= '0;
        end
        STEP_INTEG: begin
          if (fire) begin
            spike_out_q   <= 1'b1;
            potential_q   <= '0;
            refr_cnt_q    <= REFRAC_W'(REFRAC);
            spike_count_q <= spike_count_q + CNT_W'(1);
          end else begin
            potential_q <= pot_clamped;
          end
        end
        default: ;
      endcase
    end
  end

  assign nrn.spike_out   = spike_out_q;
  assign nrn.potential   = potential_q;
  assign nrn.refractory  = (refr_cnt_q != '0);
  assign nrn.spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: two instances (leak shift 2 and 4) driven with identical
// directed then random steps, each compared against a behavioural model every cycle.
module tb_lif_neuron;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_neuron_if #(.N_IN(4), .IN_W(4), .POT_W(8), .CNT_W(8)) ifa ();
  lif_neuron_if #(.N_IN(4), .IN_W(4), .POT_W(8), .CNT_W(8)) ifb ();

  lif_neuron #(.N_IN(4), .IN_W(4), .POT_W(8), .LEAK_SHIFT(2), .REFRAC(3), .CNT_W(8))
    dut_a (.clk(clk), .rst_n(rst_n), .nrn(ifa));
  lif_neuron #(.N_IN(4), .IN_W(4), .POT_W(8), .LEAK_SHIFT(4), .REFRAC(3), .CNT_W(8))
    dut_b (.clk(clk), .rst_n(rst_n), .nrn(ifb));

  int vectors = 0;
  int miscompares = 0;

  // Reference state per instance: 0 = dut_a, 1 = dut_b.
  int m_pot[2];
  int m_refr[2];
  int m_cnt[2];
  int m_spk[2];
  int shift_of[2] = '{2, 4};
  localparam int REFRAC = 3;
  localparam int POT_MAX = 255;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pot[k] = 0; m_refr[k] = 0; m_cnt[k] = 0; m_spk[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit e, input logic [3:0] sp,
                            input logic [3:0] ih, input logic [15:0] w, input int thr);
    int ex, in_sum, nxt;
    m_spk[k] = 0;
    if (!e) return;
    if (m_refr[k] > 0) begin
      m_refr[k]--;
      m_pot[k] = 0;
      return;
    end
    ex = 0; in_sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (sp[i] && !ih[i]) ex     += int'(w[i*4 +: 4]);
      if (sp[i] &&  ih[i]) in_sum += int'(w[i*4 +: 4]);
    end
    nxt = m_pot[k] - (m_pot[k] >> shift_of[k]) + ex - in_sum;
    if (nxt < 0) nxt = 0;
    if (nxt > POT_MAX) nxt = POT_MAX;
    if (thr != 0 && nxt >= thr) begin
      m_spk[k] = 1;
      m_pot[k] = 0;
      m_refr[k] = REFRAC;
      m_cnt[k] = (m_cnt[k] + 1) % 256;
    end else begin
      m_pot[k] = nxt;
    end
  endtask

  task automatic compare_all();
    check("a.spike_out",   int'(ifa.spike_out),   m_spk[0]);
    check("a.potential",   int'(ifa.potential),   m_pot[0]);
    check("a.refractory",  int'(ifa.refractory),  int'(m_refr[0] != 0));
    check("a.spike_count", int'(ifa.spike_count), m_cnt[0]);
    check("b.spike_out",   int'(ifb.spike_out),   m_spk[1]);
    check("b.potential",   int'(ifb.potential),   m_pot[1]);
    check("b.refractory",  int'(ifb.refractory),  int'(m_refr[1] != 0));
    check("b.spike_count", int'(ifb.spike_count), m_cnt[1]);
  endtask

  // One clock: drive at negedge, let the edge happen, advance model, compare.
  task automatic cycle(input bit r, input bit e, input logic [3:0] sp, input logic [3:0] ih,
                       input logic [15:0] w, input logic [7:0] thr);
    @(negedge clk);
    rst_n = r;
    ifa.en = e; ifa.in_spike = sp; ifa.inhib = ih; ifa.weight = w; ifa.threshold = thr;
    ifb.en = e; ifb.in_spike = sp; ifb.inhib = ih; ifb.weight = w; ifb.threshold = thr;
    @(posedge clk);
    #1;
    if (!r) model_reset();
    else begin
      model_step(0, e, sp, ih, w, int'(thr));
      model_step(1, e, sp, ih, w, int'(thr));
    end
    compare_all();
  endtask

  int exp_ramp[8] = '{5, 9, 12, 14, 16, 17, 18, 19};

  initial begin
    logic [15:0] w5;
    w5 = 16'h0005;
    ifa.en = 0; ifa.in_spike = 0; ifa.inhib = 0; ifa.weight = 0; ifa.threshold = 0;
    ifb.en = 0; ifb.in_spike = 0; ifb.inhib = 0; ifb.weight = 0; ifb.threshold = 0;

    // Reset state
    cycle(0, 0, 4'h0, 4'h0, 16'h0, 8'd20);
    check("rst.potential", int'(ifa.potential), 0);
    check("rst.count", int'(ifa.spike_count), 0);

    // Ramp to threshold, fire, refractory, resume
    for (int s = 0; s < 8; s++) begin
      cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
      check("ramp.potential", int'(ifa.potential), exp_ramp[s]);
    end
    cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    check("fire.spike_out", int'(ifa.spike_out), 1);
    check("fire.potential", int'(ifa.potential), 0);
    check("fire.count", int'(ifa.spike_count), 1);
    for (int s = 0; s < 3; s++) begin
      cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
      check("refr.potential", int'(ifa.potential), 0);
      check("refr.spike_out", int'(ifa.spike_out), 0);
    end
    cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    check("resume.potential", int'(ifa.potential), 5);
    check("resume.refractory", int'(ifa.refractory), 0);

    // Inhibition clamps at zero
    cycle(0, 0, 4'h0, 4'h0, 16'h0, 8'd20);
    cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    check("inh.pre", int'(ifa.potential), 9);
    cycle(1, 1, 4'hF, 4'hF, 16'hFFFF, 8'd20);
    check("inh.clamp0", int'(ifa.potential), 0);
    check("inh.nospike", int'(ifa.spike_out), 0);

    // Saturation with firing disabled
    cycle(0, 0, 4'h0, 4'h0, 16'h0, 8'd0);
    for (int s = 0; s < 12; s++) cycle(1, 1, 4'hF, 4'h0, 16'hFFFF, 8'd0);
    check("sat.potential_b", int'(ifb.potential), 255);
    check("sat.count_b", int'(ifb.spike_count), 0);

    // en gating
    cycle(0, 0, 4'h0, 4'h0, 16'h0, 8'd20);
    cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    check("gate.s1", int'(ifa.potential), 5);
    cycle(1, 0, 4'h1, 4'h0, w5, 8'd20);
    check("gate.s2", int'(ifa.potential), 5);
    cycle(1, 0, 4'h1, 4'h0, w5, 8'd20);
    check("gate.s3", int'(ifa.potential), 5);
    cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    check("gate.s4", int'(ifa.potential), 9);

    // Reset during refractory
    cycle(0, 0, 4'h0, 4'h0, 16'h0, 8'd20);
    for (int s = 0; s < 9; s++) cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    check("rr.fired", int'(ifa.refractory), 1);
    cycle(0, 1, 4'h1, 4'h0, w5, 8'd20);
    check("rr.refractory", int'(ifa.refractory), 0);
    check("rr.count", int'(ifa.spike_count), 0);
    check("rr.spike_out", int'(ifa.spike_out), 0);
    cycle(1, 1, 4'h1, 4'h0, w5, 8'd20);
    check("rr.first_step", int'(ifa.potential), 5);

    // Random steps
    for (int n = 0; n < 600; n++) begin
      logic [15:0] rw;
      logic [7:0]  rt;
      rw = 16'($urandom);
      rt = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 120));
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            rw, rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
